// File: rtl/icc_branch_unit_if.sv
// icc_branch_unit_if: ALU flag, PSR write, Bicc handshake and delay-slot signals
interface icc_branch_unit_if;
    logic       alu_n;
    logic       alu_z;
    logic       alu_v;
    logic       alu_c;
    logic       icc_we;
    logic       wr_psr_en;
    logic [3:0] wr_psr_icc;
    logic [3:0] icc;
    logic       carry_out;
    logic       br_valid;
    logic [3:0] br_cond;
    logic       br_annul;
    logic       br_ready;
    logic       br_done;
    logic       br_taken;
    logic       slot_valid;
    logic       annul_slot;

    modport master (
        output alu_n, alu_z, alu_v, alu_c, icc_we, wr_psr_en, wr_psr_icc,
        output br_valid, br_cond, br_annul, slot_valid,
        input  icc, carry_out, br_ready, br_done, br_taken, annul_slot
    );

    modport slave (
        input  alu_n, alu_z, alu_v, alu_c, icc_we, wr_psr_en, wr_psr_icc,
        input  br_valid, br_cond, br_annul, slot_valid,
        output icc, carry_out, br_ready, br_done, br_taken, annul_slot
    );
endinterface

// File: rtl/icc_branch_unit.sv
// icc_branch_unit: integer condition code register and Bicc resolver with delay-slot annul
module icc_branch_unit #(
    parameter logic [3:0] ICC_RESET = 4'b0000,
    parameter bit         ANNUL_EN  = 1'b1
) (
    input logic              clk,
    input logic              rst,
    icc_branch_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RESOLVE, DSLOT} state_t;

    state_t     state_q, state_d;
    logic [3:0] icc_q, icc_d;
    logic       done_q, done_d;
    logic       taken_q, taken_d;
    logic       annul_flag_q, annul_flag_d;
    logic       base;
    logic       cond_met;
    logic       br_ready;
    logic       accept;
    logic       slot_annul;

    // Bicc condition on committed flags; cond[3] inverts the base predicate
    always_comb begin
        case (bus.br_cond[2:0])
            3'b000:  base = 1'b0;
            3'b001:  base = icc_q[2];
            3'b010:  base = icc_q[2] | (icc_q[3] ^ icc_q[1]);
            3'b011:  base = icc_q[3] ^ icc_q[1];
            3'b100:  base = icc_q[0] | icc_q[2];
            3'b101:  base = icc_q[0];
            3'b110:  base = icc_q[3];
            default: base = icc_q[1];
        endcase
        cond_met = base ^ bus.br_cond[3];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: one resolve cycle, then wait for the delay slot
    always_comb begin
        case (state_q)
            IDLE:    state_d = accept ? RESOLVE : IDLE;
            RESOLVE: state_d = DSLOT;
            DSLOT:   state_d = bus.slot_valid ? IDLE : DSLOT;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: no accept while flags are being written, so no bypass is needed
    always_comb begin
        br_ready   = (state_q == IDLE) && !(bus.icc_we || bus.wr_psr_en);
        accept     = bus.br_valid && br_ready;
        slot_annul = (state_q == DSLOT) && annul_flag_q && bus.slot_valid;
    end

    // Flag and resolution next values; an annulled slot cannot touch icc
    always_comb begin
        icc_d        = slot_annul    ? icc_q :
                       bus.wr_psr_en ? bus.wr_psr_icc :
                       bus.icc_we    ? {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c} : icc_q;
        done_d       = accept;
        taken_d      = accept && cond_met;
        annul_flag_d = accept ? (ANNUL_EN && bus.br_annul && (!cond_met || bus.br_cond == 4'b1000))
                              : annul_flag_q;
    end

    // Flag and resolution registers
    always_ff @(posedge clk) begin
        if (rst) begin
            icc_q        <= ICC_RESET;
            done_q       <= 1'b0;
            taken_q      <= 1'b0;
            annul_flag_q <= 1'b0;
        end else begin
            icc_q        <= icc_d;
            done_q       <= done_d;
            taken_q      <= taken_d;
            annul_flag_q <= annul_flag_d;
        end
    end

    assign bus.icc        = icc_q;
    assign bus.carry_out  = icc_q[0];
    assign bus.br_ready   = br_ready;
    assign bus.br_done    = done_q;
    assign bus.br_taken   = taken_q;
    assign bus.annul_slot = slot_annul;
endmodule

// File: tb/tb_icc_branch_unit.sv
// tb_icc_branch_unit: directed checks of icc updates, Bicc resolution, annul and reset
module tb_icc_branch_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    icc_branch_unit_if bus();

    icc_branch_unit dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, v, c;
        {n, z, v, c} = f;
        case (cond)
            4'b1000: return 1'b1;
            4'b0000: return 1'b0;
            4'b1001: return ~z;
            4'b0001: return z;
            4'b1010: return ~(z | (n ^ v));
            4'b0010: return z | (n ^ v);
            4'b1011: return ~(n ^ v);
            4'b0011: return n ^ v;
            4'b1100: return ~(c | z);
            4'b0100: return c | z;
            4'b1101: return ~c;
            4'b0101: return c;
            4'b1110: return ~n;
            4'b0110: return n;
            4'b1111: return ~v;
            default: return v;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c} = 4'b0000;
        bus.icc_we     = 1'b0;
        bus.wr_psr_en  = 1'b0;
        bus.wr_psr_icc = 4'b0000;
        bus.br_valid   = 1'b0;
        bus.br_cond    = 4'b0000;
        bus.br_annul   = 1'b0;
        bus.slot_valid = 1'b0;
    endtask

    task automatic set_icc(input logic [3:0] v);
        bus.wr_psr_en  = 1'b1;
        bus.wr_psr_icc = v;
        tick();
        bus.wr_psr_en  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.icc !== 4'b0000) begin n_err++; $display("FAIL reset_icc: got %b want 0000", bus.icc); end
        n_cmp++; if (bus.br_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.br_ready); end
        n_cmp++; if (bus.br_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.br_done); end
        n_cmp++; if (bus.annul_slot !== 1'b0) begin n_err++; $display("FAIL reset_annul: got %b want 0", bus.annul_slot); end
        n_cmp++; if (bus.carry_out !== 1'b0) begin n_err++; $display("FAIL reset_carry: got %b want 0", bus.carry_out); end
    endtask

    task automatic test_be;
        bus.icc_we = 1'b1;
        {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c} = 4'b0100;
        bus.br_valid = 1'b1;
        bus.br_cond  = 4'b0001;
        bus.br_annul = 1'b0;
        #1;
        n_cmp++; if (bus.br_ready !== 1'b0) begin n_err++; $display("FAIL be_hazard_ready: got %b want 0", bus.br_ready); end
        tick();
        bus.icc_we = 1'b0;
        #1;
        n_cmp++; if (bus.icc !== 4'b0100) begin n_err++; $display("FAIL be_icc: got %b want 0100", bus.icc); end
        n_cmp++; if (bus.br_ready !== 1'b1) begin n_err++; $display("FAIL be_ready: got %b want 1", bus.br_ready); end
        tick();
        bus.br_valid = 1'b0;
        n_cmp++; if (bus.br_done !== 1'b1) begin n_err++; $display("FAIL be_done: got %b want 1", bus.br_done); end
        n_cmp++; if (bus.br_taken !== 1'b1) begin n_err++; $display("FAIL be_taken: got %b want 1", bus.br_taken); end
        n_cmp++; if (bus.br_ready !== 1'b0) begin n_err++; $display("FAIL be_resolve_ready: got %b want 0", bus.br_ready); end
        bus.icc_we = 1'b1;
        {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c} = 4'b0000;
        tick();
        bus.icc_we = 1'b0;
        n_cmp++; if (bus.icc !== 4'b0000) begin n_err++; $display("FAIL be_resolve_icc: got %b want 0000", bus.icc); end
        n_cmp++; if (bus.br_done !== 1'b0) begin n_err++; $display("FAIL be_done_pulse: got %b want 0", bus.br_done); end
        bus.slot_valid = 1'b1;
        #1;
        n_cmp++; if (bus.annul_slot !== 1'b0) begin n_err++; $display("FAIL be_annul: got %b want 0", bus.annul_slot); end
        tick();
        bus.slot_valid = 1'b0;
        #1;
        n_cmp++; if (bus.br_ready !== 1'b1) begin n_err++; $display("FAIL be_idle_ready: got %b want 1", bus.br_ready); end
    endtask

    task automatic test_bge_annul;
        set_icc(4'b1000);
        bus.br_valid = 1'b1;
        bus.br_cond  = 4'b1011;
        bus.br_annul = 1'b1;
        tick();
        n_cmp++; if (bus.br_done !== 1'b1) begin n_err++; $display("FAIL bge_done: got %b want 1", bus.br_done); end
        n_cmp++; if (bus.br_taken !== 1'b0) begin n_err++; $display("FAIL bge_taken: got %b want 0", bus.br_taken); end
        tick();
        tick();
        tick();
        n_cmp++; if (bus.br_ready !== 1'b0) begin n_err++; $display("FAIL bge_stall_ready: got %b want 0", bus.br_ready); end
        n_cmp++; if (bus.br_done !== 1'b0) begin n_err++; $display("FAIL bge_dcti_done: got %b want 0", bus.br_done); end
        n_cmp++; if (bus.annul_slot !== 1'b0) begin n_err++; $display("FAIL bge_stall_annul: got %b want 0", bus.annul_slot); end
        bus.br_valid   = 1'b0;
        bus.slot_valid = 1'b1;
        bus.icc_we     = 1'b1;
        {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c} = 4'b0101;
        #1;
        n_cmp++; if (bus.annul_slot !== 1'b1) begin n_err++; $display("FAIL bge_annul: got %b want 1", bus.annul_slot); end
        tick();
        bus.slot_valid = 1'b0;
        bus.icc_we     = 1'b0;
        n_cmp++; if (bus.icc !== 4'b1000) begin n_err++; $display("FAIL bge_annulled_we: got %b want 1000", bus.icc); end
        n_cmp++; if (bus.br_done !== 1'b0) begin n_err++; $display("FAIL bge_after_done: got %b want 0", bus.br_done); end
    endtask

    task automatic test_ba;
        set_icc(4'b0000);
        bus.br_valid = 1'b1;
        bus.br_cond  = 4'b1000;
        bus.br_annul = 1'b1;
        tick();
        bus.br_valid = 1'b0;
        n_cmp++; if (bus.br_taken !== 1'b1) begin n_err++; $display("FAIL ba_a1_taken: got %b want 1", bus.br_taken); end
        tick();
        bus.slot_valid = 1'b1;
        bus.icc_we     = 1'b1;
        {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c} = 4'b1111;
        #1;
        n_cmp++; if (bus.annul_slot !== 1'b1) begin n_err++; $display("FAIL ba_a1_annul: got %b want 1", bus.annul_slot); end
        tick();
        bus.slot_valid = 1'b0;
        bus.icc_we     = 1'b0;
        n_cmp++; if (bus.icc !== 4'b0000) begin n_err++; $display("FAIL ba_a1_icc: got %b want 0000", bus.icc); end
        bus.br_valid = 1'b1;
        bus.br_annul = 1'b0;
        tick();
        bus.br_valid = 1'b0;
        n_cmp++; if (bus.br_taken !== 1'b1) begin n_err++; $display("FAIL ba_a0_taken: got %b want 1", bus.br_taken); end
        tick();
        bus.slot_valid = 1'b1;
        bus.icc_we     = 1'b1;
        {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c} = 4'b0110;
        #1;
        n_cmp++; if (bus.annul_slot !== 1'b0) begin n_err++; $display("FAIL ba_a0_annul: got %b want 0", bus.annul_slot); end
        tick();
        bus.slot_valid = 1'b0;
        bus.icc_we     = 1'b0;
        n_cmp++; if (bus.icc !== 4'b0110) begin n_err++; $display("FAIL ba_a0_icc: got %b want 0110", bus.icc); end
    endtask

    task automatic test_wrpsr;
        bus.wr_psr_en  = 1'b1;
        bus.wr_psr_icc = 4'b0011;
        bus.icc_we     = 1'b1;
        {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c} = 4'b1100;
        tick();
        bus.wr_psr_en = 1'b0;
        bus.icc_we    = 1'b0;
        n_cmp++; if (bus.icc !== 4'b0011) begin n_err++; $display("FAIL wrpsr_icc: got %b want 0011", bus.icc); end
        n_cmp++; if (bus.carry_out !== 1'b1) begin n_err++; $display("FAIL wrpsr_carry: got %b want 1", bus.carry_out); end
        bus.br_valid = 1'b1;
        bus.br_cond  = 4'b1100;
        bus.br_annul = 1'b0;
        tick();
        bus.br_valid = 1'b0;
        n_cmp++; if (bus.br_done !== 1'b1) begin n_err++; $display("FAIL bgu_done: got %b want 1", bus.br_done); end
        n_cmp++; if (bus.br_taken !== 1'b0) begin n_err++; $display("FAIL bgu_taken: got %b want 0", bus.br_taken); end
        tick();
        bus.slot_valid = 1'b1;
        tick();
        bus.slot_valid = 1'b0;
    endtask

    task automatic test_rst_dslot;
        set_icc(4'b0101);
        bus.br_valid = 1'b1;
        bus.br_cond  = 4'b1000;
        bus.br_annul = 1'b1;
        tick();
        bus.br_valid = 1'b0;
        tick();
        rst = 1'b1;
        bus.slot_valid = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.annul_slot !== 1'b0) begin n_err++; $display("FAIL rst_dslot_annul: got %b want 0", bus.annul_slot); end
        n_cmp++; if (bus.br_ready !== 1'b1) begin n_err++; $display("FAIL rst_dslot_ready: got %b want 1", bus.br_ready); end
        n_cmp++; if (bus.br_done !== 1'b0) begin n_err++; $display("FAIL rst_dslot_done: got %b want 0", bus.br_done); end
        n_cmp++; if (bus.icc !== 4'b0000) begin n_err++; $display("FAIL rst_dslot_icc: got %b want 0000", bus.icc); end
        bus.slot_valid = 1'b0;
        bus.br_valid   = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.br_valid = 1'b0;
        #1;
        n_cmp++; if (bus.br_done !== 1'b0) begin n_err++; $display("FAIL rst_accept_done: got %b want 0", bus.br_done); end
        n_cmp++; if (bus.br_ready !== 1'b1) begin n_err++; $display("FAIL rst_accept_ready: got %b want 1", bus.br_ready); end
    endtask

    task automatic test_sweep;
        logic t;
        logic an;
        for (int f = 0; f < 16; f++) begin
            set_icc(4'(f));
            for (int c = 0; c < 16; c++) begin
                t  = ref_cond(4'(c), 4'(f));
                an = ~t | (c == 8);
                bus.br_valid = 1'b1;
                bus.br_cond  = 4'(c);
                bus.br_annul = 1'b1;
                tick();
                bus.br_valid = 1'b0;
                n_cmp++;
                if (bus.br_done !== 1'b1 || bus.br_taken !== t) begin
                    n_err++;
                    $display("FAIL sweep_taken cond=%b icc=%b: got done=%b taken=%b want done=1 taken=%b",
                             4'(c), 4'(f), bus.br_done, bus.br_taken, t);
                end
                tick();
                bus.slot_valid = 1'b1;
                #1;
                n_cmp++;
                if (bus.annul_slot !== an) begin
                    n_err++;
                    $display("FAIL sweep_annul cond=%b icc=%b: got %b want %b", 4'(c), 4'(f), bus.annul_slot, an);
                end
                tick();
                bus.slot_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_be();
        test_bge_annul();
        test_ba();
        test_wrpsr();
        test_rst_dslot();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
